// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter: shares one single-ported block RAM between an
// instruction-fetch requester (A) and a load/store requester (B).
// Round-robin arbitration with a bounded burst lock keeps either side from
// starving the other; the RAM's 1-cycle registered read data is steered back
// to whichever side issued the access.
module block_ram_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic                a_wren,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_wmask,
  output logic                a_rvalid,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic                b_wren,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_wmask,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                ram_cs,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wren,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [DATA_W/8-1:0] ram_wmask,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             SIDE_A  = 1'b0;
  localparam logic             SIDE_B  = 1'b1;

  logic             last_grant;
  logic [CNT_W-1:0] burst_cnt;
  logic             resp_valid;
  logic             resp_owner;
  logic             grant_any;
  logic             grant_side;

  // Pick this cycle's winner. Holding reset masks every grant so the RAM
  // never sees a chip-select while the arbiter is being reset.
  always_comb begin
    grant_any  = 1'b0;
    grant_side = last_grant;
    if (rst_n) begin
      if (a_valid && b_valid) begin
        grant_any  = 1'b1;
        // A saturated counter means the current owner has used its burst
        // (or the lock was released by an idle cycle): hand over.
        grant_side = (burst_cnt < CNT_MAX) ? last_grant : ~last_grant;
      end else if (a_valid) begin
        grant_any  = 1'b1;
        grant_side = SIDE_A;
      end else if (b_valid) begin
        grant_any  = 1'b1;
        grant_side = SIDE_B;
      end
    end
  end

  assign a_ready = grant_any && (grant_side == SIDE_A);
  assign b_ready = grant_any && (grant_side == SIDE_B);
  assign ram_cs  = grant_any;

  // Steer the granted request onto the RAM; fields read as zero when idle.
  always_comb begin
    ram_addr  = '0;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    ram_wmask = '0;
    if (grant_any) begin
      if (grant_side == SIDE_A) begin
        ram_addr  = a_addr;
        ram_wren  = a_wren;
        ram_wdata = a_wdata;
        ram_wmask = a_wmask;
      end else begin
        ram_addr  = b_addr;
        ram_wren  = b_wren;
        ram_wdata = b_wdata;
        ram_wmask = b_wmask;
      end
    end
  end

  // Arbitration history and the one-deep response tracker.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      // Starting as "B owned a full burst" makes the first contest go to A.
      last_grant <= SIDE_B;
      burst_cnt  <= CNT_MAX;
      resp_valid <= 1'b0;
      resp_owner <= SIDE_A;
    end else begin
      resp_valid <= grant_any;
      resp_owner <= grant_side;
      if (!grant_any) begin
        burst_cnt <= CNT_MAX;
      end else if (grant_side == last_grant) begin
        if (burst_cnt != CNT_MAX) begin
          burst_cnt <= burst_cnt + CNT_ONE;
        end
      end else begin
        last_grant <= grant_side;
        burst_cnt  <= CNT_ONE;
      end
    end
  end

  assign a_rvalid = resp_valid && (resp_owner == SIDE_A);
  assign b_rvalid = resp_valid && (resp_owner == SIDE_B);
  assign a_rdata  = a_rvalid ? ram_rdata : '0;
  assign b_rdata  = b_rvalid ? ram_rdata : '0;

endmodule
